// File: rtl/bus_arbiter.sv
// Two-port (fetch / data) round-robin arbiter in front of a single
// non-pipelined bus master. One transfer is in flight at a time:
// IDLE -> ADDR -> DATA -> IDLE. A wait counter forces error completion
// when the bus holds ready low for TIMEOUT consecutive cycles in one phase.
module bus_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_done,
  output logic [31:0] f_rdata,
  output logic        f_err,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [1:0]  m_trans,
  output logic        m_write,
  output logic [31:0] m_address,
  output logic [31:0] m_write_data,
  input  logic [31:0] m_read_data,
  input  logic        m_ready,
  input  logic        m_response,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic       OWN_FETCH    = 1'b0;
  localparam logic       OWN_DATA     = 1'b1;
  localparam logic [7:0] TIMEOUT_W    = 8'(TIMEOUT);

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic [31:0] addr_q, addr_d;
  logic        write_q, write_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  wait_q, wait_d;
  logic        f_done_q, f_done_d, f_err_q, f_err_d;
  logic        d_done_q, d_done_d, d_err_q, d_err_d;
  logic [31:0] f_rdata_q, f_rdata_d, d_rdata_q, d_rdata_d;

  logic        f_elig, d_elig, pick_data;
  logic        finish, finish_err, load_rdata, wait_expired;

  // Next-state, arbitration, latching and completion reporting.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    addr_d     = addr_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    wait_d     = wait_q;
    f_done_d   = 1'b0;
    f_err_d    = 1'b0;
    d_done_d   = 1'b0;
    d_err_d    = 1'b0;
    f_rdata_d  = f_rdata_q;
    d_rdata_d  = d_rdata_q;
    finish     = 1'b0;
    finish_err = 1'b0;
    load_rdata = 1'b0;

    // A port whose done is high this cycle is still holding the request
    // that just completed; it must not be reissued.
    f_elig       = f_req & ~f_done_q;
    d_elig       = d_req & ~d_done_q;
    // On a tie, data wins only if fetch was granted last.
    pick_data    = d_elig & (~f_elig | (last_q == OWN_FETCH));
    wait_expired = (wait_q == TIMEOUT_W - 8'd1);

    unique case (state_q)
      ST_IDLE: begin
        if (f_elig | d_elig) begin
          owner_d = pick_data;
          last_d  = pick_data;
          addr_d  = pick_data ? d_addr : f_addr;
          write_d = pick_data & d_write;
          wdata_d = pick_data ? d_wdata : 32'd0;
          wait_d  = 8'd0;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (m_ready) begin
          wait_d  = 8'd0;
          state_d = ST_DATA;
        end else begin
          wait_d = wait_q + 8'd1;
          if (wait_expired) begin
            state_d    = ST_IDLE;
            finish     = 1'b1;
            finish_err = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (m_ready) begin
          state_d    = ST_IDLE;
          finish     = 1'b1;
          finish_err = m_response;
          load_rdata = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
          if (wait_expired) begin
            state_d    = ST_IDLE;
            finish     = 1'b1;
            finish_err = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Only the owner of the finishing transfer sees done/err.
    if (finish) begin
      if (owner_q == OWN_DATA) begin
        d_done_d = 1'b1;
        d_err_d  = finish_err;
        if (load_rdata) d_rdata_d = m_read_data;
      end else begin
        f_done_d = 1'b1;
        f_err_d  = finish_err;
        if (load_rdata) f_rdata_d = m_read_data;
      end
    end
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_FETCH;
      last_q    <= OWN_DATA;
      addr_q    <= 32'd0;
      write_q   <= 1'b0;
      wdata_q   <= 32'd0;
      wait_q    <= 8'd0;
      f_done_q  <= 1'b0;
      f_err_q   <= 1'b0;
      d_done_q  <= 1'b0;
      d_err_q   <= 1'b0;
      f_rdata_q <= 32'd0;
      d_rdata_q <= 32'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, independent of statement order.
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      wait_q    <= wait_d;
      f_done_q  <= f_done_d;
      f_err_q   <= f_err_d;
      d_done_q  <= d_done_d;
      d_err_q   <= d_err_d;
      f_rdata_q <= f_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign m_trans      = (state_q == ST_ADDR) ? TRANS_NONSEQ : TRANS_IDLE;
  assign m_write      = (state_q != ST_IDLE) & write_q;
  assign m_address    = addr_q;
  assign m_write_data = wdata_q;
  assign busy         = (state_q != ST_IDLE);
  assign f_done       = f_done_q;
  assign f_err        = f_err_q;
  assign f_rdata      = f_rdata_q;
  assign d_done       = d_done_q;
  assign d_err        = d_err_q;
  assign d_rdata      = d_rdata_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios followed by randomized
// transfers, checked against a transaction-level model of arbitration,
// phase timing, timeout and completion reporting.
module tb_bus_arbiter;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_req, d_req, d_write, m_ready, m_response;
  logic [31:0] f_addr, d_addr, d_wdata, m_read_data;
  logic        f_done, f_err, d_done, d_err, m_write, busy;
  logic [31:0] f_rdata, d_rdata, m_address, m_write_data;
  logic [1:0]  m_trans;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  bit          last_is_data;  // port granted most recently (1 = data)
  int          done_port;     // port whose done is high this cycle: 0 none, 1 fetch, 2 data
  logic [31:0] exp_f_rdata, exp_d_rdata;

  bus_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_done(f_done), .f_rdata(f_rdata), .f_err(f_err),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
    .m_trans(m_trans), .m_write(m_write), .m_address(m_address),
    .m_write_data(m_write_data), .m_read_data(m_read_data),
    .m_ready(m_ready), .m_response(m_response), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_busy"},    busy, 0);
    check({pfx, "_trans"},   m_trans, 0);
    check({pfx, "_mwrite"},  m_write, 0);
    check({pfx, "_maddr"},   m_address, 0);
    check({pfx, "_mwdata"},  m_write_data, 0);
    check({pfx, "_fdone"},   f_done, 0);
    check({pfx, "_ddone"},   d_done, 0);
    check({pfx, "_ferr"},    f_err, 0);
    check({pfx, "_derr"},    d_err, 0);
    check({pfx, "_frdata"},  f_rdata, 0);
    check({pfx, "_drdata"},  d_rdata, 0);
  endtask

  task automatic model_reset();
    last_is_data = 1'b1;
    done_port    = 0;
    exp_f_rdata  = 32'd0;
    exp_d_rdata  = 32'd0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("rst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One complete transfer. Called between edges with the DUT idle.
  // aw/dw: ready-low edges applied in ADDR/DATA (>= TIMEOUT forces timeout).
  task automatic do_xfer(input bit fr, input bit dr, input logic [31:0] fa,
                         input logic [31:0] da, input bit dwr, input logic [31:0] dwd,
                         input int aw, input int dw, input logic [31:0] rd, input bit resp);
    bit ef, ed, win_d, xw, timed_out, saw_data;
    logic [31:0] xa, xwd;
    int n;
    f_req = fr; d_req = dr; f_addr = fa; d_addr = da; d_write = dwr; d_wdata = dwd;
    m_ready = 1'b0; m_response = 1'b0;
    ef = fr && (done_port != 1);
    ed = dr && (done_port != 2);
    if (!ef && !ed) begin
      tick();
      check("holdoff_busy", busy, 0);
      check("holdoff_fdone", f_done, 0);
      check("holdoff_ddone", d_done, 0);
      done_port = 0;
      ef = fr;
      ed = dr;
    end
    win_d        = (ef && ed) ? !last_is_data : ed;
    last_is_data = win_d;
    xa  = win_d ? da : fa;
    xw  = win_d ? dwr : 1'b0;
    xwd = win_d ? dwd : 32'd0;
    tick();
    // Requests and request data are irrelevant until the bus returns to idle.
    f_req = 1'($urandom_range(0, 1)); d_req = 1'($urandom_range(0, 1));
    f_addr = $urandom; d_addr = $urandom; d_wdata = $urandom; d_write = 1'($urandom_range(0, 1));

    timed_out = 1'b0;
    saw_data  = 1'b0;
    n = (aw >= TIMEOUT) ? TIMEOUT : aw;
    for (int i = 0; i <= n; i++) begin
      if (i == n && aw >= TIMEOUT) begin
        timed_out = 1'b1;
        break;
      end
      check("addr_trans", m_trans, 2'b10);
      check("addr_maddr", m_address, xa);
      check("addr_mwrite", m_write, xw);
      check("addr_busy", busy, 1);
      check("addr_fdone", f_done, 0);
      check("addr_ddone", d_done, 0);
      m_ready = (i == n);
      m_read_data = $urandom;
      m_response = 1'($urandom_range(0, 1));
      tick();
    end

    if (!timed_out) begin
      saw_data = 1'b1;
      n = (dw >= TIMEOUT) ? TIMEOUT : dw;
      for (int i = 0; i <= n; i++) begin
        if (i == n && dw >= TIMEOUT) begin
          timed_out = 1'b1;
          break;
        end
        check("data_trans", m_trans, 2'b00);
        check("data_maddr", m_address, xa);
        check("data_mwrite", m_write, xw);
        check("data_mwdata", m_write_data, xwd);
        check("data_busy", busy, 1);
        check("data_fdone", f_done, 0);
        check("data_ddone", d_done, 0);
        m_ready = (i == n);
        m_read_data = (i == n) ? rd : $urandom;
        m_response = (i == n) ? resp : 1'($urandom_range(0, 1));
        tick();
      end
    end
    m_ready = 1'b0;

    if (!timed_out) begin
      if (win_d) exp_d_rdata = rd;
      else       exp_f_rdata = rd;
    end
    check("done_fdone", f_done, !win_d);
    check("done_ddone", d_done, win_d);
    check("done_ferr", f_err, win_d ? 1'b0 : (timed_out | resp));
    check("done_derr", d_err, win_d ? (timed_out | resp) : 1'b0);
    check("done_frdata", f_rdata, exp_f_rdata);
    check("done_drdata", d_rdata, exp_d_rdata);
    check("done_busy", busy, 0);
    check("done_trans", m_trans, 2'b00);
    check("done_mwrite", m_write, 0);
    check("done_maddr", m_address, xa);
    if (saw_data) check("done_mwdata", m_write_data, xwd);
    done_port = win_d ? 2 : 1;
  endtask

  initial begin
    int r, aw, dw;
    rst = 1'b0;
    f_req = 0; d_req = 0; d_write = 0; m_ready = 0; m_response = 0;
    f_addr = 0; d_addr = 0; d_wdata = 0; m_read_data = 0;

    // Asynchronous reset before any clock edge.
    #2;
    model_reset();
    check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b1;

    // Zero-wait fetch read: NONSEQ in cycle 1, IDLE in cycle 2, done in cycle 3.
    do_xfer(1, 0, 32'h100, 32'h0, 0, 32'h0, 0, 0, 32'hDEADBEEF, 0);

    // Both ports held from reset: fetch, data, fetch, data.
    f_req = 1; d_req = 1;
    do_reset();
    for (int k = 0; k < 4; k++)
      do_xfer(1, 1, 32'h1000 + 32'(k), 32'h2000 + 32'(k), 0, 32'h0, 0, 0, $urandom, 0);

    // Data write with three ready-low cycles in DATA.
    do_xfer(0, 1, 32'h0, 32'h2000_0004, 1, 32'h1234_5678, 0, 3, 32'hA5A5_0000, 0);

    // Data read with ERROR response.
    do_xfer(0, 1, 32'h0, 32'h3000_0000, 0, 32'h0, 0, 0, 32'h0BAD_0BAD, 1);

    // Ready held low in ADDR until timeout.
    do_xfer(1, 0, 32'h4000_0000, 32'h0, 0, 32'h0, TIMEOUT, 0, 32'h0, 0);

    // Reset asserted in the middle of a DATA phase.
    f_req = 0; d_req = 0;
    tick();
    done_port = 0;
    check("pre_rst_busy", busy, 0);
    f_req = 1; f_addr = 32'h300; m_ready = 1;
    tick();
    check("pre_rst_addr", m_trans, 2'b10);
    last_is_data = 1'b0;
    tick();
    m_ready = 0;
    check("pre_rst_data_busy", busy, 1);
    check("pre_rst_data_trans", m_trans, 2'b00);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("midrst");
    tick();
    check("midrst_held_fdone", f_done, 0);
    check("midrst_held_busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;
    do_xfer(1, 0, 32'h300, 32'h0, 0, 32'h0, 0, 0, 32'hCAFE_F00D, 0);

    // Randomized transfers.
    for (int k = 0; k < 40; k++) begin
      r  = $urandom_range(1, 3);
      aw = ($urandom_range(0, 9) == 0) ? TIMEOUT + $urandom_range(0, 2) : $urandom_range(0, 3);
      dw = ($urandom_range(0, 9) == 0) ? TIMEOUT + $urandom_range(0, 2) : $urandom_range(0, 3);
      do_xfer(r[0], r[1], $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom,
              aw, dw, $urandom, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
